// File: rtl/layer_accumulator.sv
// ----------------------------------------------------------------------------
// layer_accumulator
//   Spiking-layer integrator in front of one rom_layer instance. A spike vector
//   from the previous layer is latched and its set bits are scanned one per
//   cycle, lowest first. Each set bit becomes a one-hot ROM address. The weight
//   row that comes back is added into NEURONS_OUT signed, saturating membrane
//   accumulators. The accumulators are then thresholded into the output spike
//   vector. Membrane potentials persist across samples until a neuron fires or
//   the block is reset.
//
//   Build option:
//     LAYER_LEAK_EN  when defined, every neuron that does not fire halves its
//                    potential in FIRE (arithmetic shift, floor). When it is
//                    undefined, such neurons keep their potential.
//
//   Ports:
//     clk         rising-edge clock
//     rst_n       synchronous reset, active low
//     spikes_in   input spike vector (NEURONS_IN bits)
//     in_valid    spikes_in valid
//     in_ready    block accepts a new sample (high only in IDLE)
//     rom_addr    one-hot ROM address, zero outside SCAN
//     rom_data    weight row returned by rom_layer in the same cycle
//     spikes_out  output spike vector (NEURONS_OUT bits)
//     out_valid   spikes_out valid
//     out_ready   downstream accepts spikes_out
// ----------------------------------------------------------------------------
module layer_accumulator #(
   parameter int unsigned W_SIZE      = 8,
   parameter int unsigned NEURONS_IN  = 4,
   parameter int unsigned NEURONS_OUT = 8,
   parameter int unsigned ACC_SIZE    = 16,
   parameter int          THRESHOLD   = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NEURONS_IN-1:0]         spikes_in,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [NEURONS_IN-1:0]         rom_addr,
   input  logic [NEURONS_OUT*W_SIZE-1:0] rom_data,
   output logic [NEURONS_OUT-1:0]        spikes_out,
   output logic                          out_valid,
   input  logic                          out_ready
);

   // One guard bit is enough to detect overflow of acc + weight,
   // because the weight is narrower than the accumulator.
   localparam int unsigned SUM_W = ACC_SIZE + 1;

   localparam logic signed [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
   localparam logic signed [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};
   localparam logic signed [ACC_SIZE-1:0] THR     = ACC_SIZE'(THRESHOLD);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIRE = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t                      state;
   logic [NEURONS_IN-1:0]       pending;
   logic signed [ACC_SIZE-1:0]  acc      [NEURONS_OUT];

   logic [SUM_W-1:0]            sum_ext  [NEURONS_OUT];
   logic signed [ACC_SIZE-1:0]  acc_sum  [NEURONS_OUT];
   logic signed [ACC_SIZE-1:0]  acc_keep [NEURONS_OUT];
   logic [NEURONS_OUT-1:0]      fire_vec;
   logic [NEURONS_IN-1:0]       pending_next;

   // Isolate the lowest set bit: v & -v.
   function automatic logic [NEURONS_IN-1:0] lowest_one(input logic [NEURONS_IN-1:0] v);
      return v & (~v + NEURONS_IN'(1));
   endfunction

   // Per-neuron datapath: saturating add, threshold compare, non-fire update.
   always_comb begin
      pending_next = pending & ~rom_addr;
      fire_vec     = '0;
      for (int j = 0; j < int'(NEURONS_OUT); j++) begin
         sum_ext[j]  = {acc[j][ACC_SIZE-1], acc[j]}
                     + {{(SUM_W-W_SIZE){rom_data[j*W_SIZE+W_SIZE-1]}},
                        rom_data[j*W_SIZE +: W_SIZE]};
         // Top two bits disagree only when the true sum left the ACC range.
         if (sum_ext[j][SUM_W-1] != sum_ext[j][SUM_W-2]) begin
            acc_sum[j] = sum_ext[j][SUM_W-1] ? ACC_MIN : ACC_MAX;
         end else begin
            acc_sum[j] = sum_ext[j][ACC_SIZE-1:0];
         end
         fire_vec[j] = (acc[j] >= THR);
`ifdef LAYER_LEAK_EN
         acc_keep[j] = acc[j] >>> 1;
`else
         acc_keep[j] = acc[j];
`endif
      end
   end

   // Control FSM with registered handshake, address and spike outputs.
   // rom_addr is preloaded with the next lowest pending bit so it is valid
   // for the whole SCAN cycle that consumes it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pending    <= '0;
         rom_addr   <= '0;
         spikes_out <= '0;
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
         for (int j = 0; j < int'(NEURONS_OUT); j++) begin
            acc[j] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  pending  <= spikes_in;
                  in_ready <= 1'b0;
                  if (spikes_in != '0) begin
                     state    <= SCAN;
                     rom_addr <= lowest_one(spikes_in);
                  end else begin
                     state <= FIRE;
                  end
               end
            end

            SCAN: begin
               for (int j = 0; j < int'(NEURONS_OUT); j++) begin
                  acc[j] <= acc_sum[j];
               end
               pending <= pending_next;
               if (pending_next == '0) begin
                  state    <= FIRE;
                  rom_addr <= '0;
               end else begin
                  rom_addr <= lowest_one(pending_next);
               end
            end

            FIRE: begin
               spikes_out <= fire_vec;
               for (int j = 0; j < int'(NEURONS_OUT); j++) begin
                  acc[j] <= fire_vec[j] ? '0 : acc_keep[j];
               end
               out_valid <= 1'b1;
               state     <= OUT;
            end

            OUT: begin
               // in_ready stays low here so a new sample cannot be
               // accepted in the handshake cycle.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               rom_addr  <= '0;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_accumulator.sv
// ----------------------------------------------------------------------------
// tb_layer_accumulator
//   Two instances run in lockstep on shared stimulus: the default 16-bit
//   accumulator and a 9-bit one that exercises saturation. Each instance has
//   a behavioural ROM fed from a common weight table. A reference model of the
//   membrane potentials pushes expected spike vectors onto a scoreboard
//   queue when a sample is driven. The entries are popped at the output
//   handshake.
// ----------------------------------------------------------------------------
module tb_layer_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  spikes_in;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready16,  in_ready9;
   logic [3:0]  rom_addr16,  rom_addr9;
   logic [63:0] rom_data16,  rom_data9;
   logic [7:0]  spikes_out16, spikes_out9;
   logic        out_valid16, out_valid9;

   logic [7:0]  wt [4][8];
   int          m16 [8];
   int          m9  [8];
   logic [15:0] sb [$];
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   layer_accumulator #(.ACC_SIZE(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .spikes_in(spikes_in), .in_valid(in_valid),
      .in_ready(in_ready16), .rom_addr(rom_addr16), .rom_data(rom_data16),
      .spikes_out(spikes_out16), .out_valid(out_valid16), .out_ready(out_ready));

   layer_accumulator #(.ACC_SIZE(9)) dut9 (
      .clk(clk), .rst_n(rst_n), .spikes_in(spikes_in), .in_valid(in_valid),
      .in_ready(in_ready9), .rom_addr(rom_addr9), .rom_data(rom_data9),
      .spikes_out(spikes_out9), .out_valid(out_valid9), .out_ready(out_ready));

   // Behavioural ROM: OR of the rows selected by the address.
   always_comb begin
      rom_data16 = '0;
      rom_data9  = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 8; j++) begin
            if (rom_addr16[i]) rom_data16[j*8 +: 8] = rom_data16[j*8 +: 8] | wt[i][j];
            if (rom_addr9[i])  rom_data9[j*8 +: 8]  = rom_data9[j*8 +: 8]  | wt[i][j];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v, input int bits);
      int mx = (1 << (bits - 1)) - 1;
      int mn = -(1 << (bits - 1));
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
   endfunction

   task automatic set_rows(input int r0, input int r1, input int r2, input int r3);
      for (int j = 0; j < 8; j++) begin
         wt[0][j] = 8'(r0);
         wt[1][j] = 8'(r1);
         wt[2][j] = 8'(r2);
         wt[3][j] = 8'(r3);
      end
   endtask

   function automatic void model_reset();
      for (int j = 0; j < 8; j++) begin
         m16[j] = 0;
         m9[j]  = 0;
      end
   endfunction

   // Advance the model by one sample and return {exp16, exp9}.
   function automatic logic [15:0] model_sample(input logic [3:0] s);
      logic [7:0] f16 = '0;
      logic [7:0] f9  = '0;
      for (int i = 0; i < 4; i++) begin
         if (s[i]) begin
            for (int j = 0; j < 8; j++) begin
               m16[j] = sat(m16[j] + int'($signed(wt[i][j])), 16);
               m9[j]  = sat(m9[j]  + int'($signed(wt[i][j])), 9);
            end
         end
      end
      for (int j = 0; j < 8; j++) begin
         f16[j] = (m16[j] >= 64);
         f9[j]  = (m9[j]  >= 64);
`ifdef LAYER_LEAK_EN
         m16[j] = f16[j] ? 0 : (m16[j] >>> 1);
         m9[j]  = f9[j]  ? 0 : (m9[j]  >>> 1);
`else
         if (f16[j]) m16[j] = 0;
         if (f9[j])  m9[j]  = 0;
`endif
      end
      return {f16, f9};
   endfunction

   // Drive one sample, follow the scan, hold OUT for `hold` cycles with
   // in_valid pulsing, then complete the handshake.
   task automatic send(input logic [3:0] s, input int hold);
      logic [3:0]  addrs [$];
      logic [3:0]  ea;
      logic [15:0] exp;
      int          k = 0;
      int          edges;
      int          idx = 0;
      for (int i = 0; i < 4; i++) begin
         if (s[i]) begin
            addrs.push_back(4'(1 << i));
            k++;
         end
      end
      sb.push_back(model_sample(s));

      check("in_ready_idle", {31'd0, in_ready16}, 32'd1);
      spikes_in = s;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      spikes_in = 4'h0;
      edges     = 1;
      check("in_ready_busy", {30'd0, in_ready16, in_ready9}, 32'd0);
      while (!out_valid16 && edges < 40) begin
         ea = (idx < k) ? addrs[idx] : 4'h0;
         check("rom_addr16", {28'd0, rom_addr16}, {28'd0, ea});
         check("rom_addr9",  {28'd0, rom_addr9},  {28'd0, ea});
         idx++;
         @(posedge clk); #1;
         edges++;
      end
      check("latency", 32'(edges), 32'(k + 2));
      check("out_valid9", {31'd0, out_valid9}, 32'd1);

      exp = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
      for (int c = 0; c < hold; c++) begin
         spikes_in = 4'hF;
         in_valid  = 1'b1;
         out_ready = 1'b0;
         check("hold_valid", {30'd0, out_valid16, out_valid9}, 32'd3);
         check("hold_ready", {30'd0, in_ready16, in_ready9}, 32'd0);
         check("hold_spikes", {16'd0, spikes_out16, spikes_out9}, {16'd0, exp});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      check("spikes_out16", {24'd0, spikes_out16}, {24'd0, exp[15:8]});
      check("spikes_out9",  {24'd0, spikes_out9},  {24'd0, exp[7:0]});
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      spikes_in = 4'h0;
      check("valid_drop", {30'd0, out_valid16, out_valid9}, 32'd0);
      check("ready_back", {30'd0, in_ready16, in_ready9}, 32'd3);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"}, {30'd0, in_ready16, in_ready9}, 32'd3);
      check({tag, "_valid"}, {30'd0, out_valid16, out_valid9}, 32'd0);
      check({tag, "_addr"},  {24'd0, rom_addr16, rom_addr9}, 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      spikes_in = 4'h0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_rows(0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      check("reset_spikes", {16'd0, spikes_out16, spikes_out9}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Two weight rows summing past the threshold.
      set_rows(40, 0, 30, 0);
      send(4'b0101, 0);
      // Empty sample goes straight to FIRE.
      send(4'b0000, 0);
      // Downstream back-pressure with ignored in_valid pulses.
      send(4'b0101, 5);

      // Sub-threshold residue, then a top-up that fires only without leak.
      set_rows(50, 14, 0, 0);
      send(4'b0001, 0);
      send(4'b0010, 0);

      // Negative saturation on the narrow accumulator, then recovery.
      set_rows(-128, -128, -128, -128);
      send(4'b1111, 0);
      set_rows(127, 127, 127, 127);
      send(4'b0011, 0);
      send(4'b0011, 0);

      // Reset in the middle of SCAN discards the sample and clears state.
      set_rows(40, 0, 30, 0);
      spikes_in = 4'b0111;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      check_idle("midrst");
      send(4'b0101, 0);

      // Randomised samples with per-neuron weights.
      for (int n = 0; n < 16; n++) begin
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) begin
               wt[i][j] = 8'($urandom_range(0, 255));
            end
         end
         send(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      end

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
